// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//
// Drains the read port of a synchronous FIFO and presents the words as a
// valid/ready stream at full throughput. The FIFO returns data one cycle after
// a pop, so the adapter keeps a two-entry prefetch buffer and tracks read
// credit: a pop is only issued when the buffer is sure to have room for the
// returning word.
//
// Optional feature (macro FIFO_STREAM_LAST_EN): when defined, a packet beat
// index drives m_last on every PKT_LEN-th beat. When undefined, m_last is
// tied to 0 and no packet counter exists.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered read data (valid the cycle after a pop)
//   fifo_read   FIFO pop request
//   m_valid     stream data valid
//   m_ready     downstream ready
//   m_data      stream data (head of the prefetch buffer)
//   m_last      last beat of packet
//   beat_count  number of completed stream transfers (wraps)

module fifo_stream_adapter #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16,
   parameter int PKT_LEN   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data,
   output logic                 fifo_read,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_last,
   output logic [CNT_WIDTH-1:0] beat_count
);

   if (PKT_LEN < 1) begin : g_bad_pkt_len
      $error("PKT_LEN must be >= 1");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             pending;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic [1:0]       entries;
   logic             pop;
   logic             push;

   // A word is arriving on fifo_data exactly when a pop was issued last cycle.
   assign push = pending;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Push without pop in TWO cannot happen: the read
   // credit never lets entries + in-flight exceed two.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (push) state_nxt = ONE;
         end
         ONE: begin
            if (push && !pop)      state_nxt = TWO;
            else if (!push && pop) state_nxt = EMPTY;
         end
         TWO: begin
            if (pop && !push) state_nxt = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Output logic. fifo_read depends only on registered state, fifo_empty,
   // m_ready and rst, never on fifo_data. The slot freed by this cycle's
   // transfer can be re-used by a pop issued in the same cycle.
   always_comb begin
      m_valid = 1'b0;
      entries = 2'd0;
      case (state)
         ONE: begin
            m_valid = 1'b1;
            entries = 2'd1;
         end
         TWO: begin
            m_valid = 1'b1;
            entries = 2'd2;
         end
         default: begin
            m_valid = 1'b0;
            entries = 2'd0;
         end
      endcase
      pop       = m_valid && m_ready;
      fifo_read = !rst && !fifo_empty &&
                  (({1'b0, entries} + {2'b00, pending}) < (3'd2 + {2'b00, pop}));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else begin
         pending <= fifo_read;
      end
   end

   // Prefetch buffer. head always drives m_data, so it only changes on a
   // transfer or when loading an empty buffer; that keeps m_data stable
   // under backpressure. On push+pop in ONE the arriving word goes straight
   // to head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) head <= fifo_data;
            end
            ONE: begin
               if (push && pop)       head <= fifo_data;
               else if (push && !pop) tail <= fifo_data;
            end
            TWO: begin
               if (pop) begin
                  head <= tail;
                  if (push) tail <= fifo_data;
               end
            end
            default: begin
               head <= head;
               tail <= tail;
            end
         endcase
      end
   end

   assign m_data = head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_count <= '0;
      end else if (pop) begin
         beat_count <= beat_count + CNT_WIDTH'(1);
      end
   end

`ifdef FIFO_STREAM_LAST_EN
   localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   logic [IDX_W-1:0] pkt_idx;

   // pkt_idx is the packet position of the current head beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_idx <= '0;
      end else if (pop) begin
         if (pkt_idx == LAST_IDX) pkt_idx <= '0;
         else                     pkt_idx <= pkt_idx + IDX_W'(1);
      end
   end

   assign m_last = m_valid && (pkt_idx == LAST_IDX);
`else
   assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
module tb_fifo_stream_adapter;

   localparam int WIDTH     = 8;
   localparam int CNT_WIDTH = 16;
   localparam int PKT_LEN   = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 fifo_empty = 1'b1;
   logic [WIDTH-1:0]     fifo_data = '0;
   logic                 fifo_read;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic [WIDTH-1:0]     m_data;
   logic                 m_last;
   logic [CNT_WIDTH-1:0] beat_count;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] fq[$];      // upstream FIFO contents
   logic [WIDTH-1:0] pend_wr[$]; // words to be written at next edge
   logic [WIDTH-1:0] exp_q[$];   // scoreboard: expected stream order

   fifo_stream_adapter #(
      .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .PKT_LEN(PKT_LEN)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .beat_count(beat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural synchronous FIFO: pop gives registered data next cycle,
   // writes become visible after the write edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
         while (pend_wr.size() > 0) fq.push_back(pend_wr.pop_front());
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic push_word(input logic [WIDTH-1:0] v);
      pend_wr.push_back(v);
      exp_q.push_back(v);
   endtask

   // Monitor: samples mid low phase, i.e. the values the next edge will see.
   int               rd_cnt = 0;
   int               tx_cnt = 0;
   int               idx    = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic             prev_last = 1'b0;

   initial begin
      logic [WIDTH-1:0] e;
      logic             exp_last;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            rd_cnt = 0; tx_cnt = 0; idx = 0; prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", {31'b0, m_valid}, 32'd1);
               check("stall_data", {24'b0, m_data}, {24'b0, prev_data});
               check("stall_last", {31'b0, m_last}, {31'b0, prev_last});
            end
            if (fifo_read) rd_cnt++;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", {24'b0, m_data}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", {24'b0, m_data}, {24'b0, e});
               end
`ifdef FIFO_STREAM_LAST_EN
               exp_last = ((idx % PKT_LEN) == PKT_LEN - 1);
`else
               exp_last = 1'b0;
`endif
               check("beat_last", {31'b0, m_last}, {31'b0, exp_last});
               idx++;
               tx_cnt++;
            end
            check("occupancy_le2", {31'b0, (rd_cnt - tx_cnt) <= 2}, 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      pend_wr.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_hi;
      int lat;
      bit stalled;

      // Reset state
      repeat (3) @(negedge clk);
      #3;
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_fifo_read", {31'b0, fifo_read}, 32'd0);
      check("rst_beat_count", {16'b0, beat_count}, 32'd0);
      check("rst_m_data", {24'b0, m_data}, 32'd0);
      check("rst_m_last", {31'b0, m_last}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming 0x01..0x08 with m_ready=1
      @(negedge clk);
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
      rd_hi = 0;
      lat   = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         #3;
         if (fifo_read) rd_hi++;
         if (m_valid && lat < 0) lat = c;
      end
      check("stream_latency", 32'(lat), 32'd2);
      check("stream_read_cycles", 32'(rd_hi), 32'd8);
      check("stream_beat_count", {16'b0, beat_count}, 32'd8);
      check("stream_all_out", 32'(exp_q.size()), 32'd0);
      check("stream_idle_valid", {31'b0, m_valid}, 32'd0);

      // Backpressure 0xA0..0xA5
      do_reset();
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(8'hA0 + WIDTH'(i));
      rd_hi = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #3;
         if (fifo_read) rd_hi++;
      end
      check("bp_read_twice", 32'(rd_hi), 32'd2);
      check("bp_head", {24'b0, m_data}, 32'hA0);
      check("bp_valid", {31'b0, m_valid}, 32'd1);
      check("bp_no_beats", {16'b0, beat_count}, 32'd0);
      @(negedge clk);
      m_ready = 1'b1;
      repeat (12) @(negedge clk);
      #3;
      check("bp_beat_count", {16'b0, beat_count}, 32'd6);
      check("bp_all_out", 32'(exp_q.size()), 32'd0);

      // Alternating ready with continuous writes 0x10..0x1F
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         push_word(8'h10 + WIDTH'(i));
         m_ready = ~m_ready;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         m_ready = ~m_ready;
      end
      @(negedge clk);
      m_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      check("alt_beat_count", {16'b0, beat_count}, 32'd16);
      check("alt_all_out", 32'(exp_q.size()), 32'd0);

      // FIFO drains after a single word
      do_reset();
      @(negedge clk);
      m_ready = 1'b1;
      push_word(8'h5A);
      repeat (8) @(negedge clk);
      #3;
      check("drain_beat_count", {16'b0, beat_count}, 32'd1);
      check("drain_valid", {31'b0, m_valid}, 32'd0);
      check("drain_read", {31'b0, fifo_read}, 32'd0);
      check("drain_all_out", 32'(exp_q.size()), 32'd0);

      // Reset with buffer full (TWO)
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(8'hB0 + WIDTH'(i));
      repeat (6) @(negedge clk);
      #3;
      check("full_valid", {31'b0, m_valid}, 32'd1);
      check("full_read", {31'b0, fifo_read}, 32'd0);
      check("full_head", {24'b0, m_data}, 32'hB0);
      @(negedge clk);
      #4;
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, m_valid}, 32'd0);
      check("midrst_read", {31'b0, fifo_read}, 32'd0);
      check("midrst_beat_count", {16'b0, beat_count}, 32'd0);
      check("midrst_m_data", {24'b0, m_data}, 32'd0);
      exp_q.delete();
      pend_wr.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      push_word(8'hC7);
      repeat (8) @(negedge clk);
      #3;
      check("postrst_beat_count", {16'b0, beat_count}, 32'd1);
      check("postrst_all_out", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_STREAM_LAST_EN
      // Packet framing: stall once on a last beat and hold it
      do_reset();
      @(negedge clk);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push_word(8'h60 + WIDTH'(i));
      stalled = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (m_valid && m_last && !stalled) begin
            stalled = 1'b1;
            m_ready = 1'b0;
            repeat (3) @(negedge clk);
            #3;
            check("last_hold", {31'b0, m_last}, 32'd1);
            check("last_hold_data", {24'b0, m_data}, 32'h63);
            m_ready = 1'b1;
         end
      end
      check("last_stall_seen", {31'b0, stalled}, 32'd1);
      check("last_beat_count", {16'b0, beat_count}, 32'd8);
      check("last_all_out", 32'(exp_q.size()), 32'd0);
`else
      stalled = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Sits directly downstream of the team's synchronous FIFO and drains its read port.
- FIFO read semantics: pop on read while not empty; read data is registered and valid the cycle after the pop; it holds until the next successful pop.
- Block converts that one-cycle-latency pop interface into a valid/ready stream at full throughput, using a 2-entry prefetch buffer and read-credit tracking.
- Counts delivered beats for debug.

Parameters:
WIDTH, 8, data width; must match the upstream FIFO WIDTH
CNT_WIDTH, 16, width of the delivered-beat counter
PKT_LEN, 4, beats per packet; used only when FIFO_STREAM_LAST_EN is defined; must be >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active high
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO registered read data
fifo_read  output  1  FIFO pop request
m_valid  output  1  stream data valid
m_ready  input  1  downstream ready
m_data  output  WIDTH  stream data
m_last  output  1  last beat of packet (tied 0 when feature disabled)
beat_count  output  CNT_WIDTH  number of completed stream transfers

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values, immediate on rst assertion:
  - m_valid=0, m_data=0, m_last=0, beat_count=0.
  - Buffer state EMPTY, pending=0.
  - fifo_read is forced 0 while rst=1.
- Transfer: m_valid && m_ready at a rising edge. m_data and m_last must stay stable while m_valid=1 and m_ready=0.
- Buffer FSM: EMPTY (0 entries), ONE (1), TWO (2); head entry drives m_data. m_valid=1 in ONE and TWO.
- pending register: set to 1 in the cycle after fifo_read=1, else 0. In the cycle with pending=1, fifo_data is captured into the buffer tail at the rising edge.
- Read credit (combinational):
  - pop = m_valid && m_ready.
  - fifo_read = !rst && !fifo_empty && (entries + pending - pop) < 2.
  - Never over-commits the 2 slots, so captured data is never dropped.
- FSM transitions per edge, with push = pending:
  - EMPTY: push -> ONE.
  - ONE: push&&!pop -> TWO; !push&&pop -> EMPTY; else stay.
  - TWO: pop&&!push -> ONE; pop&&push -> TWO (shift head, capture tail); push without pop is impossible by credit rule.
- Simultaneous push and pop in ONE: incoming word becomes the head in the same edge.
- Throughput:
  - Steady state with m_ready=1 and FIFO non-empty: one beat per cycle.
  - First beat: m_valid rises 2 cycles after fifo_empty falls (pop cycle, then capture edge).
- Latency: FIFO non-empty to m_valid is 2 cycles. Backpressure stall fills the buffer to TWO; fifo_read then stays 0 until a pop.
- beat_count increments by 1 per transfer and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: buffered and in-flight words are discarded and pending cleared. Upstream FIFO reset is the system's responsibility.
- fifo_empty glitch-free use: fifo_read only depends on registered state, fifo_empty and m_ready. No combinational path from fifo_data to any output.

Optional Feature:
- Macro FIFO_STREAM_LAST_EN.
- Defined:
  - A beat counter (0..PKT_LEN-1) advances on each transfer and wraps to 0.
  - m_last=1 when the head beat would be beat index PKT_LEN-1.
  - Counter resets to 0 on rst.
  - PKT_LEN=1 makes every beat last.
- Not defined: m_last is constant 0 and no packet counter logic exists.

Test Plan:
- Reset: assert rst mid-stream with buffer in TWO -> m_valid=0, fifo_read=0, beat_count=0 immediately; after release, the first beat comes from the next FIFO word.
- Streaming: FIFO preloaded 0x01..0x08, m_ready=1 -> m_valid rises cycle 2; m_data 0x01..0x08 on 8 consecutive cycles; beat_count=8; fifo_read high 8 cycles.
- Backpressure: preload 0xA0..0xA5, m_ready=0 for 5 cycles -> buffer holds 0xA0,0xA1 with m_data=0xA0 stable; fifo_read asserted exactly twice; release gives 0xA0..0xA5 in order, no loss or duplicate.
- Alternating m_ready 1/0 with continuous FIFO writes of 0x10..0x1F -> all 16 delivered in order; the credit rule never exceeds 2 entries (assertion).
- FIFO drains: single word 0x5A -> one beat 0x5A, then m_valid=0 and fifo_read=0 while fifo_empty=1.
- FIFO_STREAM_LAST_EN, PKT_LEN=4, 8 beats -> m_last=1 on beats 4 and 8 only; held stable under m_ready=0.
